// File: rtl/envelope_bank_pkg.sv
// +----------------------------------------------------------------------+
// | sound_pkg : shared widths, NRx2 register struct, field extractor     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package sound_pkg;

  localparam int VOL_W_DEF    = 4;
  localparam int PERIOD_W_DEF = 3;

  typedef struct packed {
    logic [VOL_W_DEF-1:0]    init_vol;
    logic                    increase;
    logic [PERIOD_W_DEF-1:0] period;
  } env_reg_t;

  // Width-generic field extraction; callers cast the result to the field width.
  function automatic logic [31:0] env_field(input logic [63:0] r, input int lsb, input int width);
    logic [63:0] m;
    m = (r >> lsb) & ~({64{1'b1}} << width);
    return m[31:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/envelope_bank_if.sv
// +----------------------------------------------------------------------+
// | envelope_bank_if : register-file / mixer side bundle of the bank     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface envelope_bank_if #(
  parameter int N_CH     = 3,
  parameter int VOL_W    = 4,
  parameter int PERIOD_W = 3
);
  localparam int REG_W = VOL_W + 1 + PERIOD_W;

  logic                    tick_64;
  logic [N_CH-1:0]         trigger;
  logic [N_CH*REG_W-1:0]   nrx2;
  logic [N_CH*VOL_W-1:0]   volume;
  logic [N_CH-1:0]         active;
  logic [N_CH-1:0]         dac_on;

  modport master (
    output tick_64, trigger, nrx2,
    input  volume, active, dac_on
  );

  modport slave (
    input  tick_64, trigger, nrx2,
    output volume, active, dac_on
  );
endinterface

`default_nettype wire

// File: rtl/envelope_bank_channel.sv
// +----------------------------------------------------------------------+
// | envelope_channel : one NRx2 volume envelope (ENVELOPE_RELOAD_ON_WRITE_EN) |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module envelope_channel
  import sound_pkg::*;
#(
  parameter int VOL_W    = VOL_W_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF
) (
  input  wire logic                      clk,
  input  wire logic                      rst,
  input  wire logic                      i_tick,
  input  wire logic                      i_trig,
  input  wire logic [VOL_W+PERIOD_W:0]   i_nrx2,
  output logic      [VOL_W-1:0]          o_volume,
  output logic                           o_active
);

  localparam logic [VOL_W:0]    c_vone = 1;
  localparam logic [PERIOD_W-1:0] c_tone = 1;

  logic [VOL_W-1:0]    r_vol;
  logic [PERIOD_W-1:0] r_timer;
  logic [PERIOD_W-1:0] r_period_l;
  logic                r_inc_l;
  logic                r_run;

  logic [VOL_W-1:0]    w_init;
  logic                w_inc;
  logic [PERIOD_W-1:0] w_per;
  logic [VOL_W:0]      w_up;
  logic [VOL_W:0]      w_dn;
  logic                w_trig;

  assign w_init = VOL_W'(env_field(64'(i_nrx2), PERIOD_W + 1, VOL_W));
  assign w_inc  = i_nrx2[PERIOD_W];
  assign w_per  = PERIOD_W'(env_field(64'(i_nrx2), 0, PERIOD_W));

  // The extra MSB flags overflow past max (up) or borrow below zero (down).
  assign w_up = {1'b0, r_vol} + c_vone;
  assign w_dn = {1'b0, r_vol} - c_vone;

`ifdef ENVELOPE_RELOAD_ON_WRITE_EN
  logic [VOL_W+PERIOD_W:0] r_prev;
  logic                    r_seen;

  // r_seen masks the first cycle after reset, when no prior value exists.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= '0;
      r_seen <= 1'b0;
    end else begin
      r_prev <= i_nrx2;
      r_seen <= 1'b1;
    end
  end

  assign w_trig = i_trig | (r_seen & (r_prev != i_nrx2));
`else
  assign w_trig = i_trig;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vol      <= '0;
      r_timer    <= '0;
      r_period_l <= '0;
      r_inc_l    <= 1'b0;
      r_run      <= 1'b0;
    end else if (w_trig) begin
      r_vol      <= w_init;
      r_timer    <= w_per;
      r_period_l <= w_per;
      r_inc_l    <= w_inc;
      r_run      <= (w_per != '0);
    end else if (i_tick && r_run) begin
      if (r_timer > c_tone) begin
        r_timer <= r_timer - c_tone;
      end else begin
        r_timer <= r_period_l;
        if (r_inc_l) begin
          if (w_up[VOL_W]) r_run <= 1'b0;
          else             r_vol <= w_up[VOL_W-1:0];
        end else begin
          if (w_dn[VOL_W]) r_run <= 1'b0;
          else             r_vol <= w_dn[VOL_W-1:0];
        end
      end
    end
  end

  assign o_volume = r_vol;
  assign o_active = r_run;

endmodule

`default_nettype wire

// File: rtl/envelope_bank.sv
// +----------------------------------------------------------------------+
// | envelope_bank : N_CH envelope channels (ENVELOPE_RELOAD_ON_WRITE_EN) |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module envelope_bank
  import sound_pkg::*;
#(
  parameter int N_CH     = 3,
  parameter int VOL_W    = VOL_W_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF
) (
  input  wire logic      clock,
  input  wire logic      reset,
  envelope_bank_if.slave bus
);

  localparam int REG_W = VOL_W + 1 + PERIOD_W;

  logic [N_CH*VOL_W-1:0] w_volume;
  logic [N_CH-1:0]       w_active;
  logic [N_CH-1:0]       w_dac_on;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    envelope_channel #(
      .VOL_W    (VOL_W),
      .PERIOD_W (PERIOD_W)
    ) u_ch (
      .clk      (clock),
      .rst      (reset),
      .i_tick   (bus.tick_64),
      .i_trig   (bus.trigger[g]),
      .i_nrx2   (bus.nrx2[g*REG_W +: REG_W]),
      .o_volume (w_volume[g*VOL_W +: VOL_W]),
      .o_active (w_active[g])
    );

    // DAC powers up whenever init_vol or the increase bit is nonzero.
    assign w_dac_on[g] = |bus.nrx2[g*REG_W + PERIOD_W +: VOL_W + 1];
  end

  assign bus.volume = w_volume;
  assign bus.active = w_active;
  assign bus.dac_on = w_dac_on;

endmodule

`default_nettype wire

// File: tb/tb_envelope_bank.sv
// +----------------------------------------------------------------------+
// | tb_envelope_bank : directed self-checking bench for envelope_bank    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_envelope_bank;
  import sound_pkg::*;

  logic clock;
  logic reset;
  int   n_pass;
  int   n_total;

  envelope_bank_if #(.N_CH(3), .VOL_W(4), .PERIOD_W(3)) bus ();

  envelope_bank #(.N_CH(3), .VOL_W(4), .PERIOD_W(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic logic [31:0] vol(input int ch);
    return 32'(bus.volume[ch*4 +: 4]);
  endfunction

  function automatic logic [31:0] act(input int ch);
    return 32'(bus.active[ch]);
  endfunction

  task automatic set_reg(input int ch, input logic [7:0] val);
    bus.nrx2[ch*8 +: 8] = val;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick_64 = 1'b1;
      @(negedge clock);
      bus.tick_64 = 1'b0;
      @(negedge clock);
    end
  endtask

  task automatic trig(input logic [2:0] m);
    bus.trigger = m;
    @(negedge clock);
    bus.trigger = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    env_reg_t r;
    logic [31:0] ch1_exp;
    n_pass  = 0;
    n_total = 0;
    reset       = 1'b1;
    bus.tick_64 = 1'b0;
    bus.trigger = '0;
    bus.nrx2    = '0;
    repeat (2) @(negedge clock);
    chk("rst_vol0", vol(0), 0);
    chk("rst_act", 32'(bus.active), 0);
    chk("rst_dac", 32'(bus.dac_on), 0);
    reset = 1'b0;
    @(negedge clock);

    // Decrease: 13, dec, period 4
    r = '{init_vol: 4'd13, increase: 1'b0, period: 3'd4};
    set_reg(0, r);
    trig(3'b001);
    chk("dec_init_vol", vol(0), 13);
    chk("dec_init_act", act(0), 1);
    ticks(3);
    chk("dec_t3", vol(0), 13);
    ticks(1);
    chk("dec_t4", vol(0), 12);
    ticks(12);
    chk("dec_t16", vol(0), 9);
    ticks(36);
    chk("dec_t52", vol(0), 0);
    ticks(3);
    chk("dec_t55_act", act(0), 1);
    ticks(1);
    chk("dec_t56_act", act(0), 0);
    chk("dec_t56_vol", vol(0), 0);

    // Increase to rail: 13, inc, period 2
    set_reg(0, 8'hDA);
    trig(3'b001);
    chk("inc_init", vol(0), 13);
    ticks(2);
    chk("inc_t2", vol(0), 14);
    ticks(2);
    chk("inc_t4", vol(0), 15);
    ticks(1);
    chk("inc_t5_act", act(0), 1);
    ticks(1);
    chk("inc_t6_act", act(0), 0);
    ticks(4);
    chk("inc_hold", vol(0), 15);

    // Period zero: init 8
    set_reg(0, 8'h80);
    trig(3'b001);
    chk("p0_vol", vol(0), 8);
    chk("p0_act", act(0), 0);
    ticks(100);
    chk("p0_vol_100", vol(0), 8);
    chk("p0_dac_on", 32'(bus.dac_on[0]), 1);
    set_reg(0, 8'h00);
    #1 chk("dac_00", 32'(bus.dac_on[0]), 0);
    set_reg(0, 8'h08);
    #1 chk("dac_08", 32'(bus.dac_on[0]), 1);
    set_reg(0, 8'h07);
    #1 chk("dac_07", 32'(bus.dac_on[0]), 0);
    @(negedge clock);

    // Same-cycle trigger and tick
    set_reg(0, 8'hD4);
    trig(3'b001);
    ticks(6);
    chk("sc_pre", vol(0), 12);
    bus.trigger = 3'b001;
    bus.tick_64 = 1'b1;
    @(negedge clock);
    bus.trigger = '0;
    bus.tick_64 = 1'b0;
    @(negedge clock);
    chk("sc_reload", vol(0), 13);
    ticks(3);
    chk("sc_t3", vol(0), 13);
    ticks(1);
    chk("sc_t4", vol(0), 12);

    // Independence: F1 / 0F / 73
    set_reg(0, 8'hF1);
    set_reg(1, 8'h0F);
    set_reg(2, 8'h73);
    trig(3'b111);
    chk("ind_v0", vol(0), 15);
    chk("ind_v1", vol(1), 0);
    chk("ind_v2", vol(2), 7);
    ticks(7);
    chk("ind7_v0", vol(0), 8);
    chk("ind7_v1", vol(1), 1);
    chk("ind7_v2", vol(2), 5);
    set_reg(1, 8'hA5);
    @(negedge clock);
`ifdef ENVELOPE_RELOAD_ON_WRITE_EN
    ch1_exp = 10;
`else
    ch1_exp = 1;
`endif
    chk("ind_wr_v1", vol(1), ch1_exp);
    ticks(3);
    chk("ind10_v0", vol(0), 5);
    chk("ind10_v1", vol(1), ch1_exp);
    chk("ind10_v2", vol(2), 4);

    // Reset mid-run, asserted between edges
    #2 reset = 1'b1;
    #1 chk("mrst_v0", vol(0), 0);
    chk("mrst_act", 32'(bus.active), 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    ticks(10);
    chk("mrst_post_v2", vol(2), 0);
    chk("mrst_post_act", 32'(bus.active), 0);
    trig(3'b100);
    chk("mrst_retrig_v2", vol(2), 7);
    chk("mrst_retrig_act", act(2), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/envelope_bank.md
# envelope_bank

Parametrised bank of volume-envelope generators, one per tone/noise channel, giving each channel a hardware-accurate volume envelope. Each channel latches its NRx2-format register on trigger, steps volume once every `period` frame-sequencer ticks, and stops at the rail. It runs on the system clock with a 64 Hz tick enable and sits between the channel register file and the per-channel DAC/mixer.

## Interface
- `N_CH`, 3: number of independent envelope channels.
- `VOL_W`, 4: volume width; maximum volume is 2^VOL_W-1.
- `PERIOD_W`, 3: envelope period field width.
- `REG_W` (localparam): VOL_W+1+PERIOD_W. Layout is {init_vol, increase, period}, MSB first.
- `clock` input 1: system clock. Single clock domain.
- `reset` input 1: asynchronous, active-high reset.
- `tick_64` input 1: one-cycle enable pulse at 64 Hz from the frame sequencer.
- `trigger` input N_CH: one-cycle per-channel trigger (NRx4 bit 7 write).
- `nrx2` input N_CH*REG_W: per-channel envelope registers; channel i occupies bits [i*REG_W +: REG_W].
- `volume` output N_CH*VOL_W: current volume per channel, registered.
- `active` output N_CH: envelope is still stepping.
- `dac_on` output N_CH: combinational, asserted when nrx2 bits [REG_W-1:PERIOD_W] != 0 (init_vol or increase nonzero).

## Operation
- Per-channel state: `vol` (VOL_W), `timer` (PERIOD_W), `period_l` (PERIOD_W), `inc_l` (1), `run` (1).
- The channel is in one of three states, encoded by `run` and `period_l`:
  - IDLE: after reset, or when the latched period is 0.
  - RUN: stepping.
  - DONE: rail reached.
- Trigger:
  - `vol` <= init_vol; `period_l` <= period; `inc_l` <= increase; `timer` <= period.
  - `run` <= (period != 0).
  - Register fields are latched only at trigger. Later nrx2 writes do not affect a running envelope, except as described under Configuration.
- Tick with `run`=1:
  - If `timer` > 1: `timer` decrements.
  - If `timer` == 1: `timer` <= `period_l`, and the channel steps.
- Step:
  - Increase: if `vol` < max, `vol`+1; otherwise `run` <= 0.
  - Decrease: if `vol` > 0, `vol`-1; otherwise `run` <= 0.
  - Volume never wraps. Arithmetic is done at VOL_W+1 bits internally.
- Tick with `run`=0: no change.
- Trigger and tick in the same cycle on a channel: the trigger wins and the tick is discarded for that channel.
- Channels are fully independent. Simultaneous triggers and ticks on all channels are legal.

## Timing
- Reset values: `vol`=0, `timer`=0, `period_l`=0, `inc_l`=0, `run`=0. Therefore `volume`=0 and `active`=0. `dac_on` follows nrx2.
- Reset asserted mid-envelope clears the state immediately (asynchronous). Stepping resumes only after a new trigger.
- Trigger at edge t: `volume`=init_vol and `active` are visible after edge t.
- The first step lands on the `period`-th tick after the trigger. Each later step follows `period` ticks after the previous one.
- `active` falls in the same cycle that an attempted step finds the rail. `volume` holds at the rail.
- No handshake. `tick_64` and `trigger` are sampled only on posedge `clock`.

## Configuration
- `ENVELOPE_RELOAD_ON_WRITE_EN`
  - Defined: each channel registers its previous nrx2 value. Any change between consecutive cycles acts as an implicit trigger for that channel, with the same effect as `trigger`. This is the legacy reload-on-write compatibility mode.
  - Undefined: nrx2 is latched only on `trigger`, and no previous-value registers are synthesised.

## Structure
- Package `sound_pkg` holds:
  - Default widths: VOL_W_DEF=4, PERIOD_W_DEF=3.
  - A `env_reg_t` packed struct {init_vol, increase, period}.
  - A field-extract function.
- Sub-module `envelope_channel` holds single-channel state and step logic.
- `envelope_bank` generates N_CH instances of it and does the slicing.

## Test plan
All scenarios use N_CH=3, VOL_W=4, PERIOD_W=3 unless stated.

- **Decrease:** reset, nrx2[ch0]=0xD4 (init 13, dec, period 4), trigger. Then:
  - volume=13 after 1 cycle.
  - volume=12 after 4 ticks and 9 after 16 ticks.
  - volume=0 after 52 ticks; `active` drops on the next step tick (56).
- **Increase to rail:** nrx2=0xDA (13, inc, period 2), trigger. Then:
  - volume 14 after 2 ticks and 15 after 4 ticks.
  - `active`=0 at tick 6; volume stays 15.
- **Period zero:** nrx2=0x80, trigger. Then:
  - volume=8 and active=0, with 100 ticks producing no change.
  - `dac_on`=1; nrx2=0x00 gives `dac_on`=0.
- **Same-cycle trigger and tick:** mid-envelope, assert trigger and tick_64 in the same cycle. The channel reloads init_vol and the full timer; the first step follows `period` ticks later.
- **Independence:** all three channels triggered with 0xF1, 0x0F and 0x73 simultaneously. Each channel follows its own trajectory; a ch1 write without trigger does not disturb ch1 (macro undefined). With the macro defined, the same write reloads ch1 on the next cycle.
- **Reset mid-run:** assert reset during stepping. volume=0 and active=0 immediately; ticks after release change nothing until a trigger.
